// File: rtl/mux_scan_sel_if.sv
// Channel-selector bus: channel data, select/mode controls and the selected-bit outputs.
// master drives the inputs and observes the outputs; slave is the selector.
interface mux_scan_sel_if #(
    parameter int N_CH    = 32,
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
);
    logic [N_CH-1:0]    c;
    logic [SEL_W-1:0]   sw;
    logic               scan_en;
    logic [DWELL_W-1:0] dwell;
    logic [N_CH-1:0]    mask;
    logic               o;
    logic               o_valid;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;

    modport master (
        output c, sw, scan_en, dwell, mask,
        input  o, o_valid, cur_sel, wrap
    );

    modport slave (
        input  c, sw, scan_en, dwell, mask,
        output o, o_valid, cur_sel, wrap
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Purpose: N:1 bit selector, manual (sw) or masked round-robin scan with dwell, sample strobe and wrap pulse.
// Latency: 1 clk from c/sw/scan_en to o (3 clk with MUX_SCAN_SYNC_EN defined: 2-flop input synchronisers).
// Backpressure: none; free-running, consumers sample o when o_valid is high.
module mux_scan_sel #(
    parameter int N_CH    = 32,
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_sel_if.slave bus
);
    typedef enum logic [1:0] {MANUAL, SCAN_LOAD, SCAN_DWELL} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               o_q, o_nxt;
    logic               ov_q, ov_nxt;
    logic               wrap_q, wrap_nxt;

    logic [N_CH-1:0]    c_s;
    logic [SEL_W-1:0]   sw_s;
    logic               scan_en_s;

`ifdef MUX_SCAN_SYNC_EN
    logic [N_CH-1:0]    c_m;
    logic [SEL_W-1:0]   sw_m;
    logic               scan_en_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_m       <= '0;
            c_s       <= '0;
            sw_m      <= '0;
            sw_s      <= '0;
            scan_en_m <= 1'b0;
            scan_en_s <= 1'b0;
        end else begin
            c_m       <= bus.c;
            c_s       <= c_m;
            sw_m      <= bus.sw;
            sw_s      <= sw_m;
            scan_en_m <= bus.scan_en;
            scan_en_s <= scan_en_m;
        end
    end
`else
    assign c_s       = bus.c;
    assign sw_s      = bus.sw;
    assign scan_en_s = bus.scan_en;
`endif

    // Out-of-range manual selects read as 0.
    logic man_bit;
    assign man_bit = (int'(sw_s) < N_CH) ? c_s[sw_s] : 1'b0;

    // Priority search: lowest enabled, highest enabled, and first enabled above sel_q (else wrap to lowest).
    logic [SEL_W-1:0] lo_sel, hi_sel, nxt_sel;
    logic             has_up;

    always_comb begin
        lo_sel  = '0;
        hi_sel  = '0;
        nxt_sel = '0;
        has_up  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.mask[i]) begin
                lo_sel = SEL_W'(i);
                if (i > int'(sel_q)) begin
                    nxt_sel = SEL_W'(i);
                    has_up  = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (bus.mask[i]) hi_sel = SEL_W'(i);
        end
        if (!has_up) nxt_sel = lo_sel;
    end

    // Next state; dropping scan_en wins over a dwell expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt;
        if (!scan_en_s) begin
            state_nxt = MANUAL;
            sel_nxt   = sw_s;
        end else begin
            case (state)
                MANUAL: state_nxt = SCAN_LOAD;
                SCAN_LOAD: begin
                    if (|bus.mask) begin
                        state_nxt = SCAN_DWELL;
                        sel_nxt   = lo_sel;
                        cnt_nxt   = bus.dwell;
                    end
                end
                SCAN_DWELL: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (|bus.mask) begin
                        sel_nxt = nxt_sel;
                        cnt_nxt = bus.dwell;
                    end else begin
                        state_nxt = SCAN_LOAD;
                    end
                end
                default: state_nxt = MANUAL;
            endcase
        end
    end

    // Outputs are registered from the next state so o_valid/wrap land in the counter==0 cycle.
    always_comb begin
        o_nxt    = 1'b0;
        ov_nxt   = 1'b0;
        wrap_nxt = 1'b0;
        case (state_nxt)
            MANUAL: begin
                o_nxt  = man_bit;
                ov_nxt = 1'b1;
            end
            SCAN_DWELL: begin
                o_nxt    = c_s[sel_nxt];
                ov_nxt   = (cnt_nxt == '0);
                wrap_nxt = (cnt_nxt == '0) && (sel_nxt == hi_sel);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MANUAL;
            sel_q  <= '0;
            cnt    <= '0;
            o_q    <= 1'b0;
            ov_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel_q  <= sel_nxt;
            cnt    <= cnt_nxt;
            o_q    <= o_nxt;
            ov_q   <= ov_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bus.o       = o_q;
    assign bus.o_valid = ov_q;
    assign bus.cur_sel = sel_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: reset, manual select, masked scan sweep, degenerate masks, mode exit.
module tb_mux_scan_sel;
    localparam int N_CH    = 32;
    localparam int SEL_W   = 5;
    localparam int DWELL_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mux_scan_sel_if #(.N_CH(N_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    mux_scan_sel #(.N_CH(N_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_sel, input logic e_o,
                           input logic e_ov, input logic e_wrap);
        chk({tag, ".cur_sel"}, 32'(bus.cur_sel), e_sel);
        chk({tag, ".o"},       32'(bus.o),       32'(e_o));
        chk({tag, ".o_valid"}, 32'(bus.o_valid), 32'(e_ov));
        chk({tag, ".wrap"},    32'(bus.wrap),    32'(e_wrap));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.c       = '0;
        bus.sw      = '0;
        bus.scan_en = 1'b0;
        bus.dwell   = '0;
        bus.mask    = '0;
        tick();
        tick();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);

        // Release with all-ones data, sw=5: one clock later o and o_valid are 1.
        bus.c  = 32'hFFFF_FFFF;
        bus.sw = 5'd5;
        rst    = 1'b0;
        tick();
        chk_all("release", 5, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("rst_again", 5, 1'b1, 1'b1, 1'b0);

        // Manual select with a 1-clk lag.
        bus.c  = 32'h0000_0020;
        bus.sw = 5'd5;
        tick();
        chk_all("man_sw5", 5, 1'b1, 1'b1, 1'b0);
        bus.sw = 5'd4;
        #1 chk("man_lag.cur_sel", 32'(bus.cur_sel), 32'd5);
        tick();
        chk_all("man_sw4", 4, 1'b0, 1'b1, 1'b0);

        // Scan sweep over channels 0,1,4 with dwell=2.
        bus.mask    = 32'h0000_0013;
        bus.dwell   = 8'd2;
        bus.c       = 32'h0000_0002;
        bus.scan_en = 1'b1;
        tick();
        chk_all("scan_load", 4, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 12; k++) begin
            logic [31:0] e_sel;
            case (k / 3)
                0:       e_sel = 0;
                1:       e_sel = 1;
                2:       e_sel = 4;
                default: e_sel = 0;
            endcase
            chk_all($sformatf("sweep%0d", k), e_sel, e_sel == 1, (k % 3) == 2, k == 8);
            if (k < 11) tick();
        end

        // Dwell expiry cycle (cur_sel=0, counter=0): dropping scan_en wins over the step to 1.
        bus.scan_en = 1'b0;
        bus.sw      = 5'd9;
        bus.c       = 32'h0000_0200;
        tick();
        chk_all("exit_prio", 9, 1'b1, 1'b1, 1'b0);

        // Empty mask parks in SCAN_LOAD with cur_sel held.
        bus.mask    = '0;
        bus.c       = 32'hFFFF_FFFF;
        bus.scan_en = 1'b1;
        tick();
        tick();
        tick();
        chk_all("park", 9, 1'b0, 1'b0, 1'b0);

        // Only channel 31 enabled, dwell=1: wrap with every strobe.
        bus.mask  = 32'h8000_0000;
        bus.dwell = 8'd1;
        bus.c     = 32'h8000_0000;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk_all($sformatf("single%0d", k), 31, 1'b1, (k % 2) == 1, (k % 2) == 1);
            tick();
        end

        bus.scan_en = 1'b0;
        bus.sw      = 5'd3;
        bus.c       = 32'h0000_0008;
        tick();
        chk_all("manual_back", 3, 1'b1, 1'b1, 1'b0);

        // dwell=0, all channels: one channel per cycle, strobe held high, wrap on channel 31.
        bus.mask    = 32'hFFFF_FFFF;
        bus.dwell   = 8'd0;
        bus.c       = 32'h5555_5555;
        bus.scan_en = 1'b1;
        tick();
        chk_all("load_d0", 3, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 64; k++) begin
            chk_all($sformatf("fast%0d", k), 32'(k % 32), (k % 2) == 0, 1'b1, (k % 32) == 31);
            tick();
        end

        // Reset mid-scan, then restart in manual.
        #2 rst = 1'b1;
        #1 chk_all("rst_scan", 0, 1'b0, 1'b0, 1'b0);
        bus.scan_en = 1'b0;
        bus.sw      = 5'd6;
        bus.c       = 32'h0000_0040;
        rst         = 1'b0;
        tick();
        chk_all("restart", 6, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
